// File: rtl/zap_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zap_wbuf_pkg
// Brief    : Shared FIFO entry layout and write-side FSM states.
// Revision : 1.0
// ============================================================================
package zap_wbuf_pkg;

    localparam int FIFO_WIDTH = 105;
    localparam int NC_BIT     = 104;
    localparam int BEN_LSB    = 96;
    localparam int DATA_LSB   = 32;

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_HOLD       = 2'd1,
        ST_PUSH       = 2'd2,
        ST_FLUSH_WAIT = 2'd3
    } wbuf_state_e;

endpackage
`default_nettype wire

// File: rtl/zap_wbuf_merge.sv
`default_nettype none
// ============================================================================
// Module   : zap_wbuf_merge
// Brief    : Byte-lane merge of a 32-bit store into the 64-bit staging entry.
// Revision : 1.0
// ============================================================================
module zap_wbuf_merge
    import zap_wbuf_pkg::*;
(
    input  logic [FIFO_WIDTH-1:0] stg_i,
    input  logic                  load_i,
    input  logic [31:2]           addr_i,
    input  logic [31:0]           data_i,
    input  logic [3:0]            ben_i,
    input  logic                  nocache_i,
    output logic [FIFO_WIDTH-1:0] stg_o
);

    always_comb begin
        stg_o = stg_i;
        // A fresh load starts from an empty doubleword tagged with the new address.
        if (load_i) begin
            stg_o          = '0;
            stg_o[NC_BIT]  = nocache_i;
            stg_o[31:3]    = addr_i[31:3];
        end
        for (int i = 0; i < 4; i++) begin
            if (ben_i[i]) begin
                stg_o[BEN_LSB + 4*int'(addr_i[2]) + i]             = 1'b1;
                stg_o[DATA_LSB + 8*(4*int'(addr_i[2]) + i) +: 8]   = data_i[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/zap_wbuf_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : zap_wbuf_wr_ctrl
// Brief    : CPU-side write buffer front end: store coalescing, FIFO push, flush.
// Revision : 1.0
// ============================================================================
module zap_wbuf_wr_ctrl
    import zap_wbuf_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic                  i_wclk,
    input  logic                  i_wrst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_data,
    input  logic [3:0]            i_req_ben,
    input  logic                  i_req_nocache,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    input  logic                  i_ds_idle,
    output logic                  o_fifo_wen,
    output logic [FIFO_WIDTH-1:0] o_fifo_wdata,
    input  logic                  i_fifo_wfull
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_SAT  = TW'(TIMEOUT);

    wbuf_state_e           state_q, state_d;
    logic [FIFO_WIDTH-1:0] stg_q, stg_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [FIFO_WIDTH-1:0] w_merged;
    logic                  w_match;
    logic                  w_merge_load;
    logic                  w_ready;
    logic                  w_push_req;
    logic                  w_flush_done;
    logic                  w_fifo_wen;
    logic                  w_accept;
    logic [TW-1:0]         w_timer_inc;
    logic                  w_unused_addr_lo;

    assign w_unused_addr_lo = ^i_req_addr[1:0];

    assign w_match      = (i_req_addr[31:3] == stg_q[31:3]) && !stg_q[NC_BIT] && !i_req_nocache;
    assign w_merge_load = !((state_q == ST_HOLD) && w_match);
    assign w_fifo_wen   = w_push_req && !i_fifo_wfull;
    assign w_accept     = i_req_valid && w_ready;
    assign w_timer_inc  = (timer_q == TMR_SAT) ? timer_q : timer_q + TW'(1);

    zap_wbuf_merge u_merge (
        .stg_i     (stg_q),
        .load_i    (w_merge_load),
        .addr_i    (i_req_addr[31:2]),
        .data_i    (i_req_data),
        .ben_i     (i_req_ben),
        .nocache_i (i_req_nocache),
        .stg_o     (w_merged)
    );

    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            state_q <= ST_EMPTY;
            stg_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (i_flush) begin
                    state_d = ST_FLUSH_WAIT;
                end else if (w_accept) begin
                    stg_d   = w_merged;
                    timer_d = '0;
                    state_d = i_req_nocache ? ST_PUSH : ST_HOLD;
                end
            end
            ST_HOLD: begin
                timer_d = w_timer_inc;
                if (i_flush) begin
                    state_d = ST_PUSH;
                end else if (i_req_valid && w_match) begin
                    stg_d   = w_merged;
                    timer_d = '0;
                end else if (i_req_valid) begin
                    // Non-matching store replaces the entry in the push cycle itself.
                    if (w_accept) begin
                        stg_d   = w_merged;
                        timer_d = '0;
                        state_d = i_req_nocache ? ST_PUSH : ST_HOLD;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (w_fifo_wen) begin
                    stg_d   = '0;
                    timer_d = '0;
                    state_d = i_flush ? ST_FLUSH_WAIT : ST_EMPTY;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!i_flush || i_ds_idle) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_ready      = 1'b0;
        w_push_req   = 1'b0;
        w_flush_done = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                w_ready = !i_flush;
            end
            ST_HOLD: begin
                w_ready    = !i_flush && (w_match || !i_fifo_wfull);
                w_push_req = !i_flush && i_req_valid && !w_match;
            end
            ST_PUSH: begin
                w_push_req = 1'b1;
            end
            ST_FLUSH_WAIT: begin
                w_flush_done = i_flush && i_ds_idle;
            end
            default: ;
        endcase
    end

    assign o_req_ready  = w_ready;
    assign o_fifo_wen   = w_fifo_wen;
    assign o_fifo_wdata = stg_q;
    assign o_flush_done = w_flush_done;

endmodule
`default_nettype wire
